triple_arbiter: RTL and testbench

Round-robin scheduler that shares one `triple` datapath (4-bit operand in, 6-bit product out) among `N_REQ` requesters. Each requester offers an operand on a valid/ready handshake; the arbiter grants one per cycle, computes ×3 through the shared datapath, and registers the result with the requester's ID on a single valid/ready output port with backpressure. The block sits between the operand producers and the result consumer.

---
 rtl/triple_pkg.sv | 42 ++++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/triple.sv | 11 +
 rtl/triple_arbiter.sv | 81 ++++++++
 tb/tb_triple_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/triple_pkg.sv
// Shared constants, output-stage states and the round-robin pick function
// used by the triple_arbiter slice.
package triple_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned RES_W    = 6;
  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
    logic [MAX_REQ-1:0]  grant;
  } rr_result_t;

  // First set bit of valid at or above ptr, wrapping modulo n (ptr < n assumed).
  function automatic rr_result_t rr_grant(input logic [MAX_REQ-1:0]  valid,
                                          input logic [MAX_ID_W-1:0] ptr,
                                          input int unsigned         n);
    rr_result_t          r;
    int unsigned         j;
    logic [MAX_ID_W-1:0] idx;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      idx = MAX_ID_W'(j);
      if (!r.found && (k < n) && valid[idx]) begin
        r.found      = 1'b1;
        r.idx        = idx;
        r.grant[idx] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pointer and combinational one-hot grant; grants only while the
// output stage can accept and reset is low.
module rr_arbiter
  import triple_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             accept,
  output logic [N_REQ-1:0] grant_c,
  output logic [ID_W-1:0]  grant_id_c,
  output logic             found_c
);

  logic [ID_W-1:0] rr_ptr;
  rr_result_t      pick_c;
  logic            unused_pick_c;

  always_comb begin
    pick_c     = rr_grant(MAX_REQ'(req_valid), MAX_ID_W'(rr_ptr), N_REQ);
    found_c    = pick_c.found && accept && !rst;
    grant_c    = found_c ? N_REQ'(pick_c.grant) : '0;
    grant_id_c = ID_W'(pick_c.idx);
  end

  // Upper grant/idx bits beyond N_REQ are structurally zero.
  assign unused_pick_c = ^pick_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (found_c) begin
      rr_ptr <= (32'(grant_id_c) == N_REQ - 1) ? '0 : grant_id_c + 1'b1;
    end
  end

endmodule

// File: rtl/triple.sv
// Shared x3 datapath: zero-extended operand times three, never overflows.
module triple
  import triple_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [RES_W-1:0] product_c
);

  assign product_c = RES_W'(op) + RES_W'({op, 1'b0});

endmodule

// File: rtl/triple_arbiter.sv
// Round-robin scheduler sharing one x3 datapath among N_REQ requesters, with
// a single registered result port under valid/ready backpressure.
module triple_arbiter
  import triple_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [OP_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  res_valid,
  output logic [RES_W-1:0]      res_data,
  output logic [ID_W-1:0]       res_id,
  input  logic                  res_ready
);

  out_state_e       state_q, state_d;
  logic             accept_c;
  logic             found_c;
  logic [ID_W-1:0]  grant_id_c;
  logic [OP_W-1:0]  op_c;
  logic [RES_W-1:0] product_c;

  // Drain and refill may happen in the same cycle.
  assign accept_c  = (state_q == EMPTY) || res_ready;
  assign res_valid = (state_q == FULL);

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .accept    (accept_c),
    .grant_c   (req_ready),
    .grant_id_c(grant_id_c),
    .found_c   (found_c)
  );

  // One-hot operand mux driven by the grant.
  always_comb begin
    op_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) op_c = req_data[i*OP_W +: OP_W];
    end
  end

  triple u_triple (
    .op       (op_c),
    .product_c(product_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (found_c) state_d = FULL;
      FULL:    if (!found_c && res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Result payload holds its last value across a drain without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_id   <= '0;
    end else if (found_c) begin
      res_data <= product_c;
      res_id   <= grant_id_c;
    end
  end

endmodule

// File: tb/tb_triple_arbiter.sv
// Scoreboard bench for triple_arbiter: directed scenarios plus random traffic
// checked against a round-robin reference model.
module tb_triple_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [5:0]     res_data;
  logic [1:0]     res_id;
  logic           res_ready;

  typedef struct {
    int data;
    int id;
  } exp_t;

  exp_t q[$];
  int   m_ptr;
  int   n_chk;
  int   n_pass;
  bit   started;

  triple_arbiter #(.N_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_id   (res_id),
    .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: grant is the first valid requester at or after the pointer.
  always @(negedge clk) begin
    int           g;
    logic [N-1:0] er;
    exp_t         e;
    bit           acc;
    if (started) begin
      chk("res_valid", 32'(res_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("res_data", 32'(res_data), 32'(q[0].data));
        chk("res_id", 32'(res_id), 32'(q[0].id));
      end
      acc = (q.size() == 0) || res_ready;
      g = -1;
      if (!rst && acc) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      if (rst) begin
        q.delete();
        m_ptr = 0;
      end else begin
        if (q.size() != 0 && res_ready) void'(q.pop_front());
        if (g >= 0) begin
          e.data = 3 * int'(req_data[4*g +: 4]);
          e.id   = g;
          q.push_back(e);
          m_ptr = (g + 1) % N;
        end
      end
    end
  end

  // Advance n cycles; optionally drop valid for requesters granted this cycle.
  task automatic cyc(input int n = 1, input bit clear_granted = 1'b1);
    logic [N-1:0] gl;
    repeat (n) begin
      @(negedge clk);
      gl = req_ready;
      @(posedge clk);
      #1;
      if (clear_granted) req_valid = req_valid & ~gl;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;
    started   = 1'b0;
    m_ptr     = 0;
    n_chk     = 0;
    n_pass    = 0;

    @(posedge clk);
    #1;
    started = 1'b1;
    chk("reset_res_data", 32'(res_data), 32'd0);
    chk("reset_res_id", 32'(res_id), 32'd0);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    cyc(2, 1'b0);
    rst = 1'b0;

    // single request
    req_data  = 16'h0005;
    req_valid = 4'b0001;
    cyc(3);

    // burst from a clean pointer
    do_reset();
    req_data  = 16'h4321;
    req_valid = 4'b1111;
    cyc(6);

    // backpressure while holding 45 from requester 2
    res_ready = 1'b0;
    req_data  = 16'h0F00;
    req_valid = 4'b0100;
    cyc(1);
    req_data  = 16'h0F07;
    req_valid = 4'b0001;
    cyc(3);
    res_ready = 1'b1;
    cyc(3);

    // fairness and wrap between requesters 0 and 3
    do_reset();
    req_data  = 16'h000A;
    req_valid = 4'b1001;
    cyc(6, 1'b0);
    req_valid = '0;
    cyc(2);

    // reset while full with pending requests
    res_ready = 1'b0;
    req_data  = 16'h1234;
    req_valid = 4'b1111;
    cyc(1, 1'b0);
    rst = 1'b1;
    cyc(1, 1'b0);
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_res_data", 32'(res_data), 32'd0);
    chk("midrst_first_grant", 32'(req_ready), 32'b0001);
    cyc(5);
    req_valid = '0;
    cyc(2);

    // operand sweep on requester 1
    for (int v = 0; v < 16; v++) begin
      req_data  = 16'(v) << 4;
      req_valid = 4'b0010;
      cyc(1);
    end
    req_valid = '0;
    cyc(2);

    // random traffic with backpressure and occasional withdrawn requests
    for (int c = 0; c < 400; c++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]        = 1'b1;
          req_data[4*i +: 4]  = 4'($urandom);
        end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(1);
    end

    req_valid = '0;
    res_ready = 1'b1;
    cyc(3);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
